// File: rtl/triangle_assembler_if.sv
// Vertex FIFO and rasterizer handshake bundle for the triangle assembler.
interface triangle_assembler_if;
  logic        fifo_empty;
  logic [95:0] vertex_in;
  logic [95:0] color_in;
  logic        fifo_pop;
  logic [1:0]  prim_mode;
  logic        begin_prim;
  logic        tri_valid;
  logic        tri_ready;
  logic [95:0] tri_v0;
  logic [95:0] tri_v1;
  logic [95:0] tri_v2;
  logic [95:0] tri_c0;
  logic [95:0] tri_c1;
  logic [95:0] tri_c2;
  logic [15:0] tri_count;
  logic        busy;

  modport slave (
    input  fifo_empty, vertex_in, color_in, prim_mode, begin_prim, tri_ready,
    output fifo_pop, tri_valid, tri_v0, tri_v1, tri_v2,
           tri_c0, tri_c1, tri_c2, tri_count, busy
  );

  modport master (
    output fifo_empty, vertex_in, color_in, prim_mode, begin_prim, tri_ready,
    input  fifo_pop, tri_valid, tri_v0, tri_v1, tri_v2,
           tri_c0, tri_c1, tri_c2, tri_count, busy
  );
endinterface

// File: rtl/triangle_assembler.sv
// Assembles triangles from a vertex/color FIFO in triangle-list, strip or fan
// order and hands them to the rasterizer over a valid/ready handshake.
module triangle_assembler (
  input logic             clk,
  input logic             reset,
  triangle_assembler_if.slave bus
);
  typedef enum logic {COLLECT, EMIT} state_e;
  localparam logic [1:0] MODE_TRI   = 2'b00;
  localparam logic [1:0] MODE_STRIP = 2'b01;
  localparam logic [1:0] MODE_FAN   = 2'b10;

  state_e        state_q, state_d;
  logic [1:0]    vcount_q, vcount_d;
  logic          parity_q, parity_d;
  logic [1:0]    mode_q, mode_d;
  logic [15:0]   count_q, count_d;
  logic [191:0]  slot_a_q, slot_a_d, slot_b_q, slot_b_d, slot_c_q, slot_c_d;
  logic [191:0]  emit0_q, emit0_d, emit1_q, emit1_d, emit2_q, emit2_d;
  logic [191:0]  head;
  logic          pop;
  logic          is_strip, is_fan;

  assign head     = {bus.vertex_in, bus.color_in};
  assign is_strip = (mode_q == MODE_STRIP);
  assign is_fan   = (mode_q == MODE_FAN);

  always_comb begin
    state_d  = state_q;
    vcount_d = vcount_q;
    parity_d = parity_q;
    mode_d   = mode_q;
    count_d  = count_q;
    slot_a_d = slot_a_q;
    slot_b_d = slot_b_q;
    slot_c_d = slot_c_q;
    emit0_d  = emit0_q;
    emit1_d  = emit1_q;
    emit2_d  = emit2_q;
    pop      = 1'b0;

    if (state_q == COLLECT) begin
      pop = !reset && !bus.fifo_empty && !bus.begin_prim;
      if (pop) begin
        case (vcount_q)
          2'd0: begin
            slot_a_d = head;
            vcount_d = 2'd1;
          end
          2'd1: begin
            slot_b_d = head;
            vcount_d = 2'd2;
          end
          2'd2: begin
            slot_c_d = head;
            vcount_d = 2'd3;
            state_d  = EMIT;
          end
          default: begin
            // Steady state of strip/fan: fan keeps its pivot vertex in A.
            if (!is_fan) slot_a_d = slot_b_q;
            slot_b_d = slot_c_q;
            slot_c_d = head;
            state_d  = EMIT;
          end
        endcase
        if (state_d == EMIT) begin
          // Odd strip triangles swap the first two vertices to keep winding.
          if (is_strip && parity_q) begin
            emit0_d = slot_b_d;
            emit1_d = slot_a_d;
          end else begin
            emit0_d = slot_a_d;
            emit1_d = slot_b_d;
          end
          emit2_d = slot_c_d;
        end
      end
    end else if (bus.tri_ready) begin
      state_d = COLLECT;
      count_d = count_q + 16'd1;
      if (is_strip) parity_d = !parity_q;
      if (!is_strip && !is_fan) vcount_d = 2'd0;
    end

    if (bus.begin_prim) begin
      mode_d   = bus.prim_mode;
      vcount_d = 2'd0;
      parity_d = 1'b0;
      state_d  = COLLECT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= COLLECT;
      vcount_q <= 2'd0;
      parity_q <= 1'b0;
      mode_q   <= MODE_TRI;
      count_q  <= 16'd0;
      emit0_q  <= '0;
      emit1_q  <= '0;
      emit2_q  <= '0;
    end else begin
      state_q  <= state_d;
      vcount_q <= vcount_d;
      parity_q <= parity_d;
      mode_q   <= mode_d;
      count_q  <= count_d;
      emit0_q  <= emit0_d;
      emit1_q  <= emit1_d;
      emit2_q  <= emit2_d;
    end
  end

  always_ff @(posedge clk) begin
    slot_a_q <= slot_a_d;
    slot_b_q <= slot_b_d;
    slot_c_q <= slot_c_d;
  end

  assign bus.fifo_pop  = pop;
  assign bus.tri_valid = (state_q == EMIT);
  assign bus.tri_v0    = emit0_q[191:96];
  assign bus.tri_c0    = emit0_q[95:0];
  assign bus.tri_v1    = emit1_q[191:96];
  assign bus.tri_c1    = emit1_q[95:0];
  assign bus.tri_v2    = emit2_q[191:96];
  assign bus.tri_c2    = emit2_q[95:0];
  assign bus.tri_count = count_q;
  assign bus.busy      = (vcount_q != 2'd0) || (state_q == EMIT);
endmodule

// File: tb/tb_triangle_assembler.sv
// Directed bench for triangle_assembler: list, strip, fan, backpressure,
// abort and mid-primitive reset against hand-computed vertex orders.
module tb_triangle_assembler;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  triangle_assembler_if bus ();

  triangle_assembler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [95:0] v0, v1, v2, c0, c1, c2;
  } tri_t;

  tri_t got[$];
  int   n_chk = 0;
  int   n_bad = 0;

  // FIFO model: first-word-fall-through over vertex indices
  logic [7:0] fidx [0:63];
  int         rd = 0;
  int         wr = 0;
  logic       gate;

  function automatic logic [95:0] vtx(input int i);
    logic [31:0] x;
    case (i)
      1: x = 32'h3F800000;
      2: x = 32'h40000000;
      3: x = 32'h40400000;
      4: x = 32'h40800000;
      5: x = 32'h40A00000;
      6: x = 32'h40C00000;
      default: x = 32'h0;
    endcase
    return {x, 32'(i) << 4, 32'h3F000000};
  endfunction

  function automatic logic [95:0] col(input int i);
    return {32'hA0000000 + 32'(i), 32'hB0000000 + 32'(i), 32'hC0000000 + 32'(i)};
  endfunction

  assign bus.fifo_empty = (rd == wr) || !gate;
  assign bus.vertex_in  = vtx(int'(fidx[rd[5:0]]));
  assign bus.color_in   = col(int'(fidx[rd[5:0]]));

  always @(posedge clk) if (bus.fifo_pop) rd <= rd + 1;

  always @(negedge clk)
    if (bus.tri_valid && bus.tri_ready)
      got.push_back('{bus.tri_v0, bus.tri_v1, bus.tri_v2,
                      bus.tri_c0, bus.tri_c1, bus.tri_c2});

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i);
    fidx[wr[5:0]] = 8'(i);
    wr = wr + 1;
  endtask

  task automatic start_prim(input logic [1:0] mode);
    @(posedge clk); #1;
    bus.prim_mode  = mode;
    bus.begin_prim = 1'b1;
    @(posedge clk); #1;
    bus.begin_prim = 1'b0;
  endtask

  task automatic wait_tris(input string tag, input int n);
    int cyc = 0;
    while (got.size() < n && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk(tag, 192'(got.size()), 192'(n));
  endtask

  task automatic chk_tri(input string tag, input int k, input int a, input int b, input int c);
    if (k >= got.size()) begin
      chk({tag, "_missing"}, 192'(got.size()), 192'(k + 1));
    end else begin
      chk({tag, "_0"}, {got[k].v0, got[k].c0}, {vtx(a), col(a)});
      chk({tag, "_1"}, {got[k].v1, got[k].c1}, {vtx(b), col(b)});
      chk({tag, "_2"}, {got[k].v2, got[k].c2}, {vtx(c), col(c)});
    end
  endtask

  task automatic wait_valid(input string tag);
    int cyc = 0;
    while (!bus.tri_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk(tag, 192'(bus.tri_valid), 192'(1));
  endtask

  initial begin
    reset          = 1'b1;
    gate           = 1'b1;
    bus.prim_mode  = 2'b00;
    bus.begin_prim = 1'b0;
    bus.tri_ready  = 1'b1;
    push(1);

    // Reset: no pop even with data present, outputs cleared
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pop",   192'(bus.fifo_pop),  192'(0));
    chk("rst_valid", 192'(bus.tri_valid), 192'(0));
    chk("rst_count", 192'(bus.tri_count), 192'(0));
    chk("rst_busy",  192'(bus.busy),      192'(0));
    chk("rst_v0",    {bus.tri_v0, bus.tri_c2}, 192'(0));
    @(posedge clk); #1;
    gate  = 1'b0;
    reset = 1'b0;

    // Triangle list: 1..6 -> (1,2,3),(4,5,6)
    for (int i = 2; i <= 6; i++) push(i);
    start_prim(2'b00);
    gate = 1'b1;
    wait_tris("list_n", 2);
    chk_tri("list_t0", 0, 1, 2, 3);
    chk_tri("list_t1", 1, 4, 5, 6);
    @(negedge clk);
    chk("list_count", 192'(bus.tri_count), 192'(2));
    chk("list_busy",  192'(bus.busy),      192'(0));

    // Strip: 1..5 -> (1,2,3),(3,2,4),(3,4,5)
    got.delete();
    start_prim(2'b01);
    for (int i = 1; i <= 5; i++) push(i);
    wait_tris("strip_n", 3);
    chk_tri("strip_t0", 0, 1, 2, 3);
    chk_tri("strip_t1", 1, 3, 2, 4);
    chk_tri("strip_t2", 2, 3, 4, 5);
    @(negedge clk);
    chk("strip_count", 192'(bus.tri_count), 192'(5));
    chk("strip_busy",  192'(bus.busy),      192'(1));

    // Fan: 1..5 -> (1,2,3),(1,3,4),(1,4,5)
    got.delete();
    start_prim(2'b10);
    for (int i = 1; i <= 5; i++) push(i);
    wait_tris("fan_n", 3);
    chk_tri("fan_t0", 0, 1, 2, 3);
    chk_tri("fan_t1", 1, 1, 3, 4);
    chk_tri("fan_t2", 2, 1, 4, 5);
    @(negedge clk);
    chk("fan_count", 192'(bus.tri_count), 192'(8));

    // Backpressure: held for 4 cycles with FIFO non-empty, accepted on 5th
    got.delete();
    bus.tri_ready = 1'b0;
    start_prim(2'b00);
    for (int i = 1; i <= 5; i++) push(i);
    wait_valid("bp_valid");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_pop%0d", i),   192'(bus.fifo_pop), 192'(0));
      chk($sformatf("bp_hold%0d", i),  {bus.tri_v0, bus.tri_v2}, {vtx(1), vtx(3)});
      chk($sformatf("bp_vld%0d", i),   192'(bus.tri_valid), 192'(1));
      if (i < 3) @(negedge clk);
    end
    @(posedge clk); #1;
    bus.tri_ready = 1'b1;
    wait_tris("bp_n", 1);
    chk_tri("bp_t0", 0, 1, 2, 3);
    @(negedge clk);
    chk("bp_count", 192'(bus.tri_count), 192'(9));

    // Abort: begin_prim over a stalled triangle drops it
    got.delete();
    bus.tri_ready = 1'b0;
    start_prim(2'b00);
    for (int i = 1; i <= 6; i++) push(i);
    wait_valid("ab_valid");
    @(posedge clk); #1;
    bus.begin_prim = 1'b1;
    @(negedge clk);
    chk("ab_pop", 192'(bus.fifo_pop), 192'(0));
    @(posedge clk); #1;
    bus.begin_prim = 1'b0;
    bus.tri_ready  = 1'b1;
    @(negedge clk);
    chk("ab_drop",  192'(bus.tri_valid), 192'(0));
    chk("ab_count", 192'(bus.tri_count), 192'(9));
    wait_tris("ab_n", 1);
    chk_tri("ab_t0", 0, 4, 5, 6);
    @(negedge clk);
    chk("ab_count2", 192'(bus.tri_count), 192'(10));

    // Reset mid-strip, then the latched mode is back to triangle list
    got.delete();
    start_prim(2'b01);
    for (int i = 1; i <= 4; i++) push(i);
    wait_tris("rs_n", 2);
    chk_tri("rs_t1", 1, 3, 2, 4);
    @(posedge clk); #1;
    gate = 1'b0;
    @(negedge clk);
    chk("rs_busy_pre", 192'(bus.busy), 192'(1));
    got.delete();
    @(posedge clk); #1;
    for (int i = 1; i <= 3; i++) push(i);
    gate  = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk("rs_pop", 192'(bus.fifo_pop), 192'(0));
    @(negedge clk);
    chk("rs_valid", 192'(bus.tri_valid), 192'(0));
    chk("rs_count", 192'(bus.tri_count), 192'(0));
    chk("rs_busy",  192'(bus.busy),      192'(0));
    chk("rs_out0",  {bus.tri_v0, bus.tri_c0}, 192'(0));
    chk("rs_out1",  {bus.tri_v1, bus.tri_v2}, 192'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    wait_tris("rs_after_n", 1);
    chk_tri("rs_after_t0", 0, 1, 2, 3);
    @(negedge clk);
    chk("rs_after_count", 192'(bus.tri_count), 192'(1));
    chk("rs_after_busy",  192'(bus.busy),      192'(0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/triangle_assembler.md
TRIANGLE_ASSEMBLER -- requirements
Module: triangle_assembler

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port fifo_empty  input  1  vertex/color FIFO pair empty (first-word-fall-through; head data valid whenever low).
REQ-004 SHALL have port vertex_in  input  96  FIFO head vertex {x[95:64], y[63:32], z[31:0]}, IEEE-754 single.
REQ-005 SHALL have port color_in  input  96  FIFO head color {red, green, blue}.
REQ-006 SHALL have port fifo_pop  output  1  combinational pop strobe; one entry is consumed per cycle it is high.
REQ-007 SHALL have port prim_mode  input  2  00 triangles, 01 strip, 10 fan, 11 treated as triangles.
REQ-008 SHALL have port begin_prim  input  1  one-cycle pulse starting a new primitive (glBegin).
REQ-009 SHALL have port tri_valid  output  1  triangle available to rasterizer.
REQ-010 SHALL have port tri_ready  input  1  rasterizer accepts triangle.
REQ-011 SHALL have ports tri_v0, tri_v1, tri_v2  output  96 each  triangle vertices in emit order.
REQ-012 SHALL have ports tri_c0, tri_c1, tri_c2  output  96 each  matching colors.
REQ-013 SHALL have port tri_count  output  16  triangles accepted since reset, wraps 0xFFFF->0x0000.
REQ-014 SHALL have port busy  output  1  high when vertex count nonzero or tri_valid high.

Function
REQ-015 SHALL implement two states: COLLECT and EMIT.
REQ-016 SHALL in COLLECT drive fifo_pop = !fifo_empty && !begin_prim; in EMIT fifo_pop SHALL be 0.
REQ-017 SHALL on each pop capture vertex_in/color_in into slot registers A,B,C per mode and increment vcount (2-bit, saturating at 3).
REQ-018 SHALL in triangles mode fill A,B,C in order; on third pop go to EMIT with (A,B,C), then clear vcount to 0 on acceptance.
REQ-019 SHALL in strip mode fill A,B,C for the first three pops; each later pop shifts A<=B, B<=C, C<=new and goes to EMIT.
REQ-020 SHALL in strip mode emit (A,B,C) when parity=0 and (B,A,C) when parity=1; parity toggles on each accepted strip triangle.
REQ-021 SHALL in fan mode fill A,B,C for the first three pops; each later pop keeps A, shifts B<=C, C<=new, goes to EMIT.
REQ-022 SHALL register triangle outputs on the edge that enters EMIT; tri_valid high in the next cycle (pop-to-valid latency 1 cycle).
REQ-023 SHALL hold all tri_* outputs stable while tri_valid && !tri_ready.
REQ-024 SHALL on tri_valid && tri_ready deassert tri_valid next cycle, increment tri_count, return to COLLECT (no pop in the accepting cycle).
REQ-025 SHALL on begin_prim (any state) latch prim_mode, clear vcount and parity, drop any pending triangle (tri_valid 0 next cycle, tri_count unchanged), enter COLLECT.
REQ-026 SHALL ignore prim_mode changes except when latched by begin_prim or reset.
REQ-027 SHALL, if begin_prim and tri_ready coincide with tri_valid high, treat the triangle as accepted (count increments) and still apply begin_prim clearing.
REQ-028 SHALL never pop while fifo_empty is high; empty mid-primitive simply stalls with vcount held.

Reset
REQ-029 SHALL on reset: state COLLECT, vcount 0, parity 0, latched mode triangles, tri_valid 0, all tri_v*/tri_c* 0, tri_count 0, busy 0; reset overrides begin_prim and handshakes.
REQ-030 SHALL, with reset high, drive fifo_pop 0.

Verification
REQ-031 Triangles: begin_prim mode 00, 6 vertices x=1.0..6.0 (0x3F800000..0x40C00000), tri_ready=1 -> two triangles x(1,2,3),(4,5,6), tri_count=2.
REQ-032 Strip: mode 01, 5 vertices x=1..5 -> triangles (1,2,3),(3,2,4),(3,4,5), tri_count=3.
REQ-033 Fan: mode 10, 5 vertices x=1..5 -> triangles (1,2,3),(1,3,4),(1,4,5).
REQ-034 Backpressure: tri_ready=0 for 4 cycles after valid, FIFO non-empty -> outputs stable, fifo_pop 0 throughout, accepted on 5th cycle.
REQ-035 Abort: begin_prim while tri_valid high and tri_ready=0 -> tri_valid 0 next cycle, tri_count unchanged, next 3 vertices form fresh triangle.
REQ-036 Reset mid-strip after 4 vertices -> all outputs 0 next cycle, following 3 vertices in triangles mode produce one triangle, tri_count=1.
